cont_sinc_updown: RTL and testbench
===================================

# cont_sinc_updown

Parametrised synchronous up/down modulo counter, the fully synchronous successor to the team's ripple-clocked JK down-counter. All state bits switch on the same `clk` edge, so there is no ripple skew or decode glitching. Adds a programmable modulus, direction control, parallel load, count enable, wrap/saturate mode and terminal-count/wrap flags. Used wherever the design needs a divider, event counter or cyclic index.

## Interface
- `WIDTH`, default 6: counter width in bits; legal range ≥ 1.
- `MODULUS`, default 64: count range is 0 .. MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  parallel-load strobe.
- `d`  in  WIDTH  parallel-load value.
- `sat`  in  1  boundary mode: 1 = saturate at the end of the range, 0 = wrap around.
- `q`  out  WIDTH  count value (registered).
- `qnot`  out  WIDTH  bitwise complement of `q`; always exactly `~q`.
- `tc`  out  1  terminal count (combinational).
- `wrapped`  out  1  one-cycle registered pulse after a wrap.

## Operation
- Priority at each rising edge of `clk`: `reset` > `load` > `en` > hold.
- **reset**:
  - `q` ← 0 and `qnot` ← all ones.
  - `wrapped` ← 0.
- **load**:
  - If `d` ≤ MODULUS-1, then `q` ← `d`.
  - If `d` > MODULUS-1, then `q` ← MODULUS-1 (clamped).
  - `wrapped` ← 0. The `en`, `up` and `sat` inputs are ignored on a load cycle.
- **en=1, up=1**:
  - If `q` < MODULUS-1, then `q` ← `q`+1.
  - If `q` = MODULUS-1 and `sat`=0, then `q` ← 0 and `wrapped` ← 1.
  - If `q` = MODULUS-1 and `sat`=1, then `q` holds and `wrapped` ← 0.
- **en=1, up=0**:
  - If `q` > 0, then `q` ← `q`-1.
  - If `q` = 0 and `sat`=0, then `q` ← MODULUS-1 and `wrapped` ← 1.
  - If `q` = 0 and `sat`=1, then `q` holds and `wrapped` ← 0.
- **en=0**: `q` holds and `wrapped` ← 0.
- `tc` = `en` & (`up` ? `q`==MODULUS-1 : `q`==0).
  - `tc` is asserted in both sat modes, so it can be used as a cascade enable for a following counter.
- Arithmetic is computed at WIDTH+1 bits internally. When MODULUS = 2^WIDTH, wrap is the natural rollover, but it must still be produced by the explicit compare above.
- When MODULUS < 2^WIDTH, `q` never holds a value ≥ MODULUS.
- Changing `up` mid-count takes effect on the next enabled edge; the count does not jump.

## Timing
- Count latency: 1 cycle. `q` reflects an edge's action immediately after that edge.
- `tc` is combinational from `q`, `en` and `up`. It has no register delay and is valid within the same cycle.
- `wrapped` is high for exactly the one cycle following the wrapping edge; it coincides with `q` showing the wrapped value.
- Reset asserted mid-count: the next edge forces `q`=0 regardless of `load`/`en`. Counting resumes on the first edge with `reset`=0.
- There is no asynchronous path from any input to `q` or `wrapped`.

## Test plan
- Reset behaviour: assert `reset` with `en`=1 and `load`=1 (`d`=5) → after the edge, `q`=0, `qnot`=6'b111111, `wrapped`=0.
- Default down-count wrap: `up`=0, `en`=1, `sat`=0 starting from reset → `q` sequence 0, 63, 62, 61 …; `wrapped`=1 only in the cycle where `q`=63; `tc`=1 only while `q`=0.
- Modulo-10 up-count (MODULUS=10, WIDTH=4): 12 enabled edges from 0 → sequence 1..9, 0, 1, 2; `tc`=1 while `q`=9; `wrapped` pulses once, when `q` returns to 0.
- Saturate mode: `sat`=1, `up`=1, load 62, then 4 enabled edges → `q` = 63, 63, 63, 63; `wrapped` stays 0; `tc` stays 1.
- Load priority and clamping (MODULUS=10): `load`=1, `en`=1, `d`=13 → `q`=9. Then `load`=0, `en`=0 for 3 edges → `q` holds 9 and `tc`=0.
- Mid-count reset and direction change: count up to 5, set `up`=0 → next edge gives 4. Assert `reset` in the following cycle → `q`=0 on the next edge.

Source files
------------

// File: rtl/cont_sinc_updown.sv
`default_nettype none
// ============================================================================
//  Module   : cont_sinc_updown
//  Purpose  : Fully synchronous up/down modulo counter with programmable
//             modulus, parallel load (clamped to the range), count enable,
//             wrap/saturate boundary mode and terminal-count / wrap flags.
//  Ports    :
//    clk      in   clock, all state changes on the rising edge
//    reset    in   synchronous active-high reset
//    en       in   count enable
//    up       in   direction, 1 = increment, 0 = decrement
//    load     in   parallel-load strobe (beats en)
//    d        in   parallel-load value, clamped to MODULUS-1
//    sat      in   1 = saturate at the range ends, 0 = wrap around
//    q        out  registered count, always in 0 .. MODULUS-1
//    qnot     out  bitwise complement of q
//    tc       out  terminal count, combinational from q/en/up
//    wrapped  out  one-cycle registered pulse following a wrapping edge
//  Revision : 1.0  initial release
// ============================================================================
module cont_sinc_updown #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             tc,
  output logic             wrapped
);

  // The modulus itself needs WIDTH+1 bits when MODULUS = 2^WIDTH, which is
  // why the boundary compares are carried out one bit wider than the count.
  localparam logic [WIDTH:0]   c_mod_ext = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] c_max_q   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrapped;

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_inc_ext;
  logic [WIDTH-1:0] w_dec;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_d_over;
  logic [WIDTH-1:0] w_d_clamped;
  logic [WIDTH-1:0] w_count_next;
  logic             w_wrapped_next;

  assign w_q_ext   = {1'b0, r_count};
  assign w_inc_ext = w_q_ext + (WIDTH+1)'(1);
  assign w_dec     = r_count - WIDTH'(1);

  // Top of range detected as "q+1 reaches the modulus". Even for a full
  // power-of-two range the wrap comes from this compare, not from the
  // natural carry-out of the adder.
  assign w_at_max  = (w_inc_ext == c_mod_ext);
  assign w_at_zero = (r_count == '0);

  // Load values beyond the range are clamped to the last legal count.
  assign w_d_over    = ({1'b0, d} >= c_mod_ext);
  assign w_d_clamped = w_d_over ? c_max_q : d;

  always_comb begin
    w_count_next   = r_count;
    w_wrapped_next = 1'b0;
    if (load) begin
      w_count_next = w_d_clamped;
    end else if (en) begin
      if (up) begin
        if (!w_at_max) begin
          w_count_next = w_inc_ext[WIDTH-1:0];
        end else if (!sat) begin
          w_count_next   = '0;
          w_wrapped_next = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_count_next = w_dec;
        end else if (!sat) begin
          w_count_next   = c_max_q;
          w_wrapped_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_wrapped <= w_wrapped_next;
    end
  end

  assign q       = r_count;
  assign qnot    = ~r_count;
  assign wrapped = r_wrapped;

  // Asserted in both boundary modes so it can enable a cascaded stage.
  assign tc = en & (up ? w_at_max : w_at_zero);

endmodule
`default_nettype wire

// File: tb/tb_cont_sinc_updown.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cont_sinc_updown
//  Purpose  : Self-checking bench for cont_sinc_updown. Two instances share
//             the control inputs: a full-range 6-bit counter (modulus 64)
//             and a 4-bit modulo-10 counter. Each is compared against an
//             integer reference model on directed and random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cont_sinc_updown;

  logic       clk = 1'b0;
  logic       reset, en, up, load, sat;
  logic [5:0] d64;
  logic [3:0] d10;
  logic [5:0] q64, qn64;
  logic [3:0] q10, qn10;
  logic       tc64, tc10, wr64, wr10;

  int errors = 0;
  int checks = 0;

  int  m64_q, m10_q;
  bit  m64_w, m10_w;

  always #5 clk = ~clk;

  cont_sinc_updown #(.WIDTH(6), .MODULUS(64)) dut64 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d64),
    .sat(sat), .q(q64), .qnot(qn64), .tc(tc64), .wrapped(wr64)
  );

  cont_sinc_updown #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d10),
    .sat(sat), .q(q10), .qnot(qn10), .tc(tc10), .wrapped(wr10)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour straight from the counter's rules on plain integers.
  function automatic void model_next(input int cur, input int modulus,
                                     input bit r, input bit l, input bit e,
                                     input bit u, input bit s, input int dv,
                                     output int nq, output bit nw);
    nq = cur;
    nw = 1'b0;
    if (r) nq = 0;
    else if (l) nq = (dv > modulus - 1) ? modulus - 1 : dv;
    else if (e && u) begin
      if (cur < modulus - 1) nq = cur + 1;
      else if (!s) begin nq = 0; nw = 1'b1; end
    end else if (e && !u) begin
      if (cur > 0) nq = cur - 1;
      else if (!s) begin nq = modulus - 1; nw = 1'b1; end
    end
  endfunction

  function automatic bit model_tc(input int cur, input int modulus, input bit e, input bit u);
    return e && (u ? (cur == modulus - 1) : (cur == 0));
  endfunction

  // Called at a falling edge: drive, check tc, take a rising edge, check state.
  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input bit s, input logic [5:0] dv64, input logic [3:0] dv10);
    int  nq;
    bit  nw;
    reset = r; en = e; up = u; load = l; sat = s; d64 = dv64; d10 = dv10;
    #1;
    check("tc64", {31'b0, tc64}, {31'b0, model_tc(m64_q, 64, e, u)});
    check("tc10", {31'b0, tc10}, {31'b0, model_tc(m10_q, 10, e, u)});
    @(posedge clk);
    model_next(m64_q, 64, r, l, e, u, s, int'(dv64), nq, nw);
    m64_q = nq; m64_w = nw;
    model_next(m10_q, 10, r, l, e, u, s, int'(dv10), nq, nw);
    m10_q = nq; m10_w = nw;
    #1;
    check("q64",    {26'b0, q64},  m64_q);
    check("qnot64", {26'b0, qn64}, {26'b0, ~6'(m64_q)});
    check("wrap64", {31'b0, wr64}, {31'b0, m64_w});
    check("q10",    {28'b0, q10},  m10_q);
    check("qnot10", {28'b0, qn10}, {28'b0, ~4'(m10_q)});
    check("wrap10", {31'b0, wr10}, {31'b0, m10_w});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; sat = 1'b0;
    d64 = '0; d10 = '0;
    m64_q = 0; m10_q = 0; m64_w = 1'b0; m10_w = 1'b0;
    @(negedge clk);

    // Reset beats load and enable.
    step(1, 1, 1, 1, 0, 6'd5, 4'd5);
    check("rst_q64_const", {26'b0, q64}, 32'd0);
    check("rst_qnot64_const", {26'b0, qn64}, 32'd63);

    // Down-count from zero wraps to the top of the range.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 6'd0, 4'd0);

    // Up-count across the modulo-10 boundary.
    step(1, 0, 1, 0, 0, 6'd0, 4'd0);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 6'd0, 4'd0);

    // Saturation at the top.
    step(0, 0, 1, 1, 1, 6'd62, 4'd8);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 6'd0, 4'd0);
    check("sat_q64_const", {26'b0, q64}, 32'd63);

    // Load beats enable; out-of-range load clamps; hold with en=0.
    step(0, 1, 1, 1, 0, 6'd13, 4'd13);
    check("clamp_q10_const", {28'b0, q10}, 32'd9);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 6'd0, 4'd0);

    // Direction change mid-count, then reset mid-count.
    step(1, 0, 1, 0, 0, 6'd0, 4'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 6'd0, 4'd0);
    step(0, 1, 0, 0, 0, 6'd0, 4'd0);
    check("dir_q64_const", {26'b0, q64}, 32'd4);
    step(1, 1, 0, 0, 0, 6'd0, 4'd0);

    // Saturation at the bottom.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 6'd0, 4'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 4) == 0), 6'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
